// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, single-step shift/rotate/ASR,
// and a multi-step engine that repeats one operation a programmed number
// of times behind a start/busy/done handshake.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             sclk,
  input  logic             srst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  output logic [WIDTH-1:0] Q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done,
  output logic             dbg_state
);

  // Operation encoding shared by single-step and multi-step paths.
  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Handshake: start is sampled only in IDLE. A nonzero amount raises busy
  // from the next cycle for exactly amount cycles; done then pulses for one
  // cycle with busy low. amount==0 skips RUN and pulses done next cycle.
  // start is accepted again in the cycle done is high.
  state_t           state;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] d_r;
  logic [CNT_W-1:0] cnt;

  // One step of the selected operation applied to the current contents.
  function automatic logic [WIDTH-1:0] step_fn(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] d,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH-1:0] r;
    r = q;
    case (op)
      OP_HOLD: r = q;
      OP_LOAD: r = d;
      OP_SHL:  r = {q[WIDTH-2:0], sl};
      OP_SHR:  r = {sr, q[WIDTH-1:1]};
      OP_ROL:  r = {q[WIDTH-2:0], q[WIDTH-1]};
      OP_ROR:  r = {q[0], q[WIDTH-1:1]};
      OP_ASR:  r = {q[WIDTH-1], q[WIDTH-1:1]};
      OP_CLR:  r = '0;
      default: r = q;
    endcase
    return r;
  endfunction

  // Control FSM and datapath; D is captured at start so LOAD repeats use the
  // value present at launch rather than whatever appears while busy.
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      state <= IDLE;
      Q     <= '0;
      op_r  <= OP_HOLD;
      d_r   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_r <= mode;
            d_r  <= D;
            cnt  <= amount;
            if (amount != '0) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end else if (en) begin
            Q <= step_fn(mode, Q, D, sin_l, sin_r);
          end
        end
        RUN: begin
          Q   <= step_fn(op_r, Q, d_r, sin_l, sin_r);
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sout_l    = Q[WIDTH-1];
  assign sout_r    = Q[0];
  assign dbg_state = (state == RUN);

endmodule
